// File: rtl/seg7_scan_ctrl.sv
// Four-digit 7-segment scan controller: serial binary-to-BCD conversion feeding a multiplexed display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above the units position.
module seg7_scan_ctrl #(
    parameter int PRESCALE = 50000
) (
    input  logic        CLK_i,
    input  logic        RST_i,
    input  logic [11:0] IN_i,
    input  logic        VALID_i,
    output logic        READY_o,
    output logic [6:0]  SEG_o,
    output logic [3:0]  DIG_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]    state;
    logic [11:0]   bin_sr;
    logic [15:0]   bcd;
    logic [15:0]   bcd_adj;
    logic [3:0]    iter;
    logic [15:0]   disp;
    logic [PW-1:0] presc;
    logic [1:0]    index;
    logic [3:0]    digit_sel;
    logic          blank;
    logic [6:0]    seg_next;
    logic [3:0]    dig_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Double-dabble correction: each nibble is adjusted on its own, never carrying upward.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state  <= ST_IDLE;
            bin_sr <= '0;
            bcd    <= '0;
            iter   <= '0;
            disp   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (VALID_i) begin
                        bin_sr <= IN_i;
                        bcd    <= '0;
                        iter   <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    iter          <= iter + 4'd1;
                    if (iter == 4'd11)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    disp  <= bcd;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign READY_o = (state == ST_IDLE);

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            presc <= '0;
            index <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            index <= index + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        digit_sel = 4'd0;
        blank     = 1'b0;
        case (index)
            2'd0: digit_sel = disp[3:0];
            2'd1: digit_sel = disp[7:4];
            2'd2: digit_sel = disp[11:8];
            default: digit_sel = disp[15:12];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is blank only when it and every more significant digit are zero.
        case (index)
            2'd1: blank = (disp[15:4] == 12'd0);
            2'd2: blank = (disp[15:8] == 8'd0);
            2'd3: blank = (disp[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        seg_next = blank ? 7'h00 : decode(digit_sel);
        dig_next = 4'b0001 << index;
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            SEG_o <= 7'h3F;
            DIG_o <= 4'b0001;
        end else begin
            SEG_o <= seg_next;
            DIG_o <= dig_next;
        end
    end

endmodule
